// File: rtl/conv_layer_ctrl.sv
// Purpose : sequencer for one conv layer pass; drives current_state to the weight cache / PE array.
// Latency : start sampled in INIT/IDLE -> PRELOAD next cycle; pass is PRELOAD_CYCLES+ARRAY_SIZE*(K*K+1)+(ARRAY_SIZE-1) cycles.
// Backpr. : none; i_start is ignored while busy, i_clear aborts to INIT on the next edge.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   i_start                 level-sampled pass request (only honoured in INIT/IDLE)
//   i_clear                 synchronous abort, wins over i_start
//   o_state                 current_state register (INIT=0 .. IDLE=7)
//   o_row_cnt / o_cyc_cnt   output-row index / cycle index within the current state
//   o_busy                  high outside INIT and IDLE
//   o_out_valid / o_done    one-cycle pulses: result row ready / pass complete
module conv_layer_ctrl #(
  parameter  int KERNEL_SIZE    = 3,
  parameter  int IMAGE_SIZE     = 8,
  parameter  int ARRAY_SIZE     = 6,
  parameter  int PRELOAD_CYCLES = 3,
  // cyc_cnt is shared by PRELOAD and the ROW_k states, so size it for the longer one
  localparam int CYC_MAX = ((KERNEL_SIZE > PRELOAD_CYCLES) ? KERNEL_SIZE : PRELOAD_CYCLES) - 1,
  localparam int CYC_W   = (CYC_MAX > 0) ? $clog2(CYC_MAX + 1) : 1,
  localparam int ROW_W   = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  output logic [2:0]       o_state,
  output logic [ROW_W-1:0] o_row_cnt,
  output logic [CYC_W-1:0] o_cyc_cnt,
  output logic             o_busy,
  output logic             o_out_valid,
  output logic             o_done
);

  // Encoding is fixed: the weight cache decodes these values directly.
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_ROW0    = 3'd2,
    ST_ROW1    = 3'd3,
    ST_ROW2    = 3'd4,
    ST_BIAS    = 3'd5,
    ST_LOAD    = 3'd6,
    ST_IDLE    = 3'd7
  } state_e;

  localparam logic [CYC_W-1:0] PRE_LAST = CYC_W'(PRELOAD_CYCLES - 1);
  localparam logic [CYC_W-1:0] K_LAST   = CYC_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_SIZE - 1);

  // The PE array width is tied to the valid-convolution output width.
  if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_cfg_err
    $error("conv_layer_ctrl: ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
  end

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      row_q       <= '0;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cyc_d       = cyc_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_INIT, ST_IDLE: begin
        if (i_start) begin
          state_d = ST_PRELOAD;
          row_d   = '0;
          cyc_d   = '0;
        end
      end
      ST_PRELOAD: begin
        if (cyc_q == PRE_LAST) begin
          state_d = ST_ROW0;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_ROW0, ST_ROW1, ST_ROW2: begin
        if (cyc_q == K_LAST) begin
          cyc_d = '0;
          case (state_q)
            ST_ROW0: state_d = ST_ROW1;
            ST_ROW1: state_d = ST_ROW2;
            default: state_d = ST_BIAS;
          endcase
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_BIAS: begin
        // The row's accumulation completes here; flag it in the following cycle.
        cyc_d       = '0;
        out_valid_d = 1'b1;
        if (row_q == ROW_LAST) begin
          state_d = ST_IDLE;
          row_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // row_cnt still names the finished row during LOAD; it advances as ROW_0 begins.
        state_d = ST_ROW0;
        row_d   = row_q + 1'b1;
        cyc_d   = '0;
      end
      default: begin
        state_d = ST_INIT;
        row_d   = '0;
        cyc_d   = '0;
      end
    endcase

    // Abort overrides everything, including the pulses of a completing row.
    if (i_clear) begin
      state_d     = ST_INIT;
      row_d       = '0;
      cyc_d       = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = !((state_d == ST_INIT) || (state_d == ST_IDLE));
  end

  assign o_state     = state_q;
  assign o_row_cnt   = row_q;
  assign o_cyc_cnt   = cyc_q;
  assign o_busy      = busy_q;
  assign o_out_valid = out_valid_q;
  assign o_done      = done_q;

endmodule
